// File: rtl/mult_ctrl_pkg.sv
// Shared op codes and controller state encoding for the shift-and-add multiplier.
// Imported by the controller and by the X/Y/Z/ULA datapath for op decode.
package mult_ctrl_pkg;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic ULA_PASS_A = 1'b0;
  localparam logic ULA_ADD    = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    LOAD_Y = 3'd2,
    ADD    = 3'd3,
    SHIFT  = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter: clear has priority over increment; last flags the final pass.
// Holds its value when neither clear nor increment is asserted.
module mult_iter_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add multiplier controller: start/done handshake, iteration counter,
// early exit once Y is zero. Outputs decode from the registered state.
module mult_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_lsb,
  input  logic             y_zero,
  output logic [1:0]       x_op,
  output logic [1:0]       y_op,
  output logic [1:0]       z_op,
  output logic             ula_op,
  output logic             in_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  import mult_ctrl_pkg::*;

  state_e state_q;
  state_e state_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

  mult_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (iter),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_op    = OP_HOLD;
    y_op    = OP_HOLD;
    z_op    = OP_HOLD;
    ula_op  = ULA_PASS_A;
    in_sel  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_X;
      end
      LOAD_X: begin
        x_op    = OP_LOAD;
        y_op    = OP_CLEAR;
        z_op    = OP_CLEAR;
        busy    = 1'b1;
        state_d = LOAD_Y;
      end
      LOAD_Y: begin
        y_op    = OP_LOAD;
        in_sel  = 1'b1;
        busy    = 1'b1;
        cnt_clr = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        busy = 1'b1;
        // y_zero wins over y_lsb so a glitched status pair never loads Z
        if (y_zero) begin
          state_d = DONE;
        end else begin
          ula_op  = ULA_ADD;
          if (y_lsb) z_op = OP_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        x_op    = OP_SHIFT;
        y_op    = OP_SHIFT;
        busy    = 1'b1;
        cnt_inc = 1'b1;
        state_d = cnt_last ? DONE : ADD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? LOAD_X : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench: controller driving a behavioural X/Y/Z datapath, hand-computed
// products, latencies and per-cycle op traces.
module tb_mult_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       y_lsb;
  logic       y_zero;
  logic [1:0] x_op;
  logic [1:0] y_op;
  logic [1:0] z_op;
  logic       ula_op;
  logic       in_sel;
  logic       busy;
  logic       done;
  logic [2:0] iter;

  logic [3:0] opa;
  logic [3:0] opb;
  logic       force_both;
  logic [7:0] x_reg;
  logic [3:0] y_reg;
  logic [7:0] z_reg;
  logic [3:0] mux;
  logic [9:0] obs;
  logic [9:0] trace [0:40];
  logic [9:0] exp35 [1:10];

  int checks;
  int errors;
  int done_cnt;
  int zload_cnt;

  mult_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .y_lsb  (y_lsb),
    .y_zero (y_zero),
    .x_op   (x_op),
    .y_op   (y_op),
    .z_op   (z_op),
    .ula_op (ula_op),
    .in_sel (in_sel),
    .busy   (busy),
    .done   (done),
    .iter   (iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: 8-bit X and Z, 4-bit Y
  assign mux    = in_sel ? opb : opa;
  assign y_lsb  = force_both | y_reg[0];
  assign y_zero = force_both | (y_reg == 4'd0);
  assign obs    = {busy, done, x_op, y_op, z_op, ula_op, in_sel};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= 8'd0;
      y_reg <= 4'd0;
      z_reg <= 8'd0;
    end else begin
      case (x_op)
        2'b01:   x_reg <= {4'd0, mux};
        2'b10:   x_reg <= x_reg << 1;
        2'b11:   x_reg <= 8'd0;
        default: x_reg <= x_reg;
      endcase
      case (y_op)
        2'b01:   y_reg <= mux;
        2'b10:   y_reg <= y_reg >> 1;
        2'b11:   y_reg <= 4'd0;
        default: y_reg <= y_reg;
      endcase
      case (z_op)
        2'b01:   z_reg <= ula_op ? (z_reg + x_reg) : x_reg;
        2'b11:   z_reg <= 8'd0;
        default: z_reg <= z_reg;
      endcase
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (z_op == 2'b01) zload_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Pulse start for one sample edge, then trace outputs until done (bounded).
  task automatic run(input logic [3:0] a, input logic [3:0] b, output int lat);
    bit seen;
    opa   = a;
    opb   = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      trace[lat] = obs;
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    int lat;
    int d0;
    int z0;
    int busy_seen;
    checks = 0; errors = 0; done_cnt = 0; zload_cnt = 0;
    rst = 1'b1; start = 1'b0; opa = 4'd0; opb = 4'd0; force_both = 1'b0;
    exp35[1] = 10'b1001111100;  exp35[2] = 10'b1000010001;
    exp35[3] = 10'b1000000110;  exp35[4] = 10'b1010100000;
    exp35[5] = 10'b1000000010;  exp35[6] = 10'b1010100000;
    exp35[7] = 10'b1000000110;  exp35[8] = 10'b1010100000;
    exp35[9] = 10'b1000000000;  exp35[10] = 10'b0100000000;

    #3;
    chk("reset_outputs", {22'd0, obs}, 32'd0);
    chk("reset_iter", {29'd0, iter}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {22'd0, obs}, 32'd0);

    // 3 x 5: early exit through ADD with y_zero
    d0 = done_cnt; z0 = zload_cnt;
    run(4'd3, 4'd5, lat);
    chk("m35_latency", lat, 10);
    chk("m35_product", {24'd0, z_reg}, 15);
    chk("m35_iter", {29'd0, iter}, 3);
    for (int i = 1; i <= 10; i++) chk($sformatf("m35_trace%0d", i), {22'd0, trace[i]}, {22'd0, exp35[i]});
    chk("m35_zloads", zload_cnt - z0, 2);
    @(negedge clk);
    chk("m35_done_width", {31'd0, done}, 0);
    chk("m35_idle", {22'd0, obs}, 32'd0);
    chk("m35_done_count", done_cnt - d0, 1);

    // Y = 0: LOAD_X, LOAD_Y, ADD, DONE
    d0 = done_cnt; z0 = zload_cnt;
    run(4'd9, 4'd0, lat);
    chk("y0_latency", lat, 4);
    chk("y0_product", {24'd0, z_reg}, 0);
    chk("y0_zloads", zload_cnt - z0, 0);
    chk("y0_iter", {29'd0, iter}, 0);
    @(negedge clk);
    chk("y0_done_count", done_cnt - d0, 1);

    // 15 x 15: all WIDTH passes, exit from SHIFT on the counter, no trailing ADD
    d0 = done_cnt; z0 = zload_cnt;
    run(4'd15, 4'd15, lat);
    chk("m1515_latency", lat, 11);
    chk("m1515_product", {24'd0, z_reg}, 225);
    chk("m1515_zloads", zload_cnt - z0, 4);
    chk("m1515_iter", {29'd0, iter}, 4);
    chk("m1515_last_shift", {22'd0, trace[10]}, {22'd0, 10'b1010100000});
    @(negedge clk);
    chk("m1515_done_count", done_cnt - d0, 1);

    // start held high: 2 x 3 then 5 x 1 back to back
    d0 = done_cnt;
    opa = 4'd2; opb = 4'd3; start = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done && lat < 40);
    chk("held1_latency", lat, 8);
    chk("held1_product", {24'd0, z_reg}, 6);
    opa = 4'd5; opb = 4'd1;
    @(negedge clk);
    chk("held_reenter_loadx", {22'd0, obs}, {22'd0, 10'b1001111100});
    lat = 1;
    do begin @(negedge clk); lat++; end while (!done && lat < 40);
    start = 1'b0;
    chk("held2_latency", lat, 6);
    chk("held2_product", {24'd0, z_reg}, 5);
    @(negedge clk);
    chk("held_done_count", done_cnt - d0, 2);
    chk("held_idle", {22'd0, obs}, 32'd0);

    // y_zero and y_lsb both high in ADD: no Z load, straight to DONE
    opa = 4'd3; opb = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    force_both = 1'b1;
    #1;
    chk("both_zop_hold", {30'd0, z_op}, 0);
    chk("both_ula_pass", {31'd0, ula_op}, 0);
    @(negedge clk);
    force_both = 1'b0;
    chk("both_done", {31'd0, done}, 1);
    chk("both_product", {24'd0, z_reg}, 0);
    @(negedge clk);

    // reset during the third ADD cycle
    opa = 4'd3; opb = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    chk("rmid_pre_zop", {30'd0, z_op}, 1);
    chk("rmid_pre_iter", {29'd0, iter}, 2);
    rst = 1'b1;
    #1;
    chk("rmid_outputs", {22'd0, obs}, 32'd0);
    chk("rmid_iter", {29'd0, iter}, 0);
    d0 = done_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    busy_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("rmid_no_done", done_cnt - d0, 0);
    chk("rmid_stays_idle", busy_seen, 0);
    chk("rmid_idle_outputs", {22'd0, obs}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
